// File: rtl/seq_num_parser_if.sv
// Bundle between the received-message field extractor, seq_num_parser and the
// session manager: digit stream in, sequence verdict and counter update out.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

interface seq_num_parser_if #(
    parameter int BIN_WIDTH = 32,
    parameter int HOST_ADDR = `HOST_ADDR_WIDTH
);
    logic                 field_start_i;
    logic                 digit_valid_i;
    logic [7:0]           digit_i;
    logic                 field_end_i;
    logic [HOST_ADDR-1:0] host_addr_i;
    logic [BIN_WIDTH-1:0] expected_seq_num_i;

    logic                 busy_o;
    logic [BIN_WIDTH-1:0] seq_num_o;
    logic [3:0]           width_o;
    logic                 seq_valid_o;
    logic                 in_seq_o;
    logic                 gap_o;
    logic                 too_low_o;
    logic                 format_err_o;
    logic                 update_seq_counter_o;
    logic [HOST_ADDR-1:0] seq_counter_loc_o;
    logic [BIN_WIDTH-1:0] new_seq_num_o;

    modport master (
        output field_start_i, digit_valid_i, digit_i, field_end_i,
               host_addr_i, expected_seq_num_i,
        input  busy_o, seq_num_o, width_o, seq_valid_o, in_seq_o, gap_o,
               too_low_o, format_err_o, update_seq_counter_o,
               seq_counter_loc_o, new_seq_num_o
    );

    modport slave (
        input  field_start_i, digit_valid_i, digit_i, field_end_i,
               host_addr_i, expected_seq_num_i,
        output busy_o, seq_num_o, width_o, seq_valid_o, in_seq_o, gap_o,
               too_low_o, format_err_o, update_seq_counter_o,
               seq_counter_loc_o, new_seq_num_o
    );
endinterface

// File: rtl/seq_num_parser.sv
// Receive-side MsgSeqNum (tag 34) parser: ASCII digits to binary, format
// validation, comparison with the expected number and counter-update request.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

module seq_num_parser #(
    parameter int BIN_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int HOST_ADDR  = `HOST_ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    seq_num_parser_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [4:0] MAX_CNT = 5'(MAX_DIGITS);

    logic [1:0]           state;
    logic [BIN_WIDTH-1:0] acc;
    logic [3:0]           cnt;
    logic                 err;
    logic                 lead_zero;
    logic [HOST_ADDR-1:0] host_q;

    logic [BIN_WIDTH-1:0] acc_nx;
    logic [3:0]           cnt_nx;
    logic                 err_nx;
    logic                 lead_zero_nx;
    logic                 is_digit;
    logic [3:0]           digit_val;
    logic [BIN_WIDTH+3:0] prod;
    logic                 fmt_nx;

    logic [BIN_WIDTH-1:0] seq_num_r;
    logic [3:0]           width_r;
    logic                 seq_valid_r;
    logic                 in_seq_r;
    logic                 gap_r;
    logic                 too_low_r;
    logic                 format_err_r;
    logic                 update_r;
    logic [HOST_ADDR-1:0] loc_r;
    logic [BIN_WIDTH-1:0] new_seq_r;

    // Accumulator state after absorbing this cycle's byte; the verdict is taken
    // from these values so a digit coinciding with field_end_i is counted.
    always_comb begin
        is_digit     = (bus.digit_i >= 8'h30) && (bus.digit_i <= 8'h39);
        digit_val    = bus.digit_i[3:0];
        prod         = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                       + {{BIN_WIDTH{1'b0}}, digit_val};
        acc_nx       = acc;
        cnt_nx       = cnt;
        err_nx       = err;
        lead_zero_nx = lead_zero;
        if (bus.digit_valid_i) begin
            cnt_nx = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
            if ({1'b0, cnt_nx} > MAX_CNT) err_nx = 1'b1;
            if (lead_zero) err_nx = 1'b1;
            if (!is_digit) begin
                err_nx = 1'b1;
            end else begin
                if (cnt == 4'd0 && digit_val == 4'd0) lead_zero_nx = 1'b1;
                if (|prod[BIN_WIDTH+3:BIN_WIDTH]) begin
                    err_nx = 1'b1;
                    acc_nx = '1;
                end else begin
                    acc_nx = prod[BIN_WIDTH-1:0];
                end
            end
        end
        fmt_nx = err_nx || (cnt_nx == 4'd0);
    end

    // FSM plus registered verdict; a new field_start_i always wins and
    // silently abandons whatever field was in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            lead_zero    <= 1'b0;
            host_q       <= '0;
            seq_num_r    <= '0;
            width_r      <= '0;
            seq_valid_r  <= 1'b0;
            in_seq_r     <= 1'b0;
            gap_r        <= 1'b0;
            too_low_r    <= 1'b0;
            format_err_r <= 1'b0;
            update_r     <= 1'b0;
            loc_r        <= '0;
            new_seq_r    <= '0;
        end else begin
            seq_valid_r  <= 1'b0;
            in_seq_r     <= 1'b0;
            gap_r        <= 1'b0;
            too_low_r    <= 1'b0;
            format_err_r <= 1'b0;
            update_r     <= 1'b0;
            if (bus.field_start_i) begin
                state     <= ACCUM;
                acc       <= '0;
                cnt       <= '0;
                err       <= 1'b0;
                lead_zero <= 1'b0;
                host_q    <= bus.host_addr_i;
            end else begin
                case (state)
                    ACCUM: begin
                        acc       <= acc_nx;
                        cnt       <= cnt_nx;
                        err       <= err_nx;
                        lead_zero <= lead_zero_nx;
                        if (bus.field_end_i) begin
                            state        <= CHECK;
                            seq_valid_r  <= 1'b1;
                            seq_num_r    <= acc_nx;
                            width_r      <= cnt_nx;
                            format_err_r <= fmt_nx;
                            in_seq_r     <= !fmt_nx && (acc_nx == bus.expected_seq_num_i);
                            gap_r        <= !fmt_nx && (acc_nx >  bus.expected_seq_num_i);
                            too_low_r    <= !fmt_nx && (acc_nx <  bus.expected_seq_num_i);
                            update_r     <= !fmt_nx && (acc_nx == bus.expected_seq_num_i);
                            loc_r        <= host_q;
                            new_seq_r    <= acc_nx + 1'b1;
                        end
                    end
                    CHECK:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy_o               = (state != IDLE);
    assign bus.seq_num_o            = seq_num_r;
    assign bus.width_o              = width_r;
    assign bus.seq_valid_o          = seq_valid_r;
    assign bus.in_seq_o             = in_seq_r;
    assign bus.gap_o                = gap_r;
    assign bus.too_low_o            = too_low_r;
    assign bus.format_err_o         = format_err_r;
    assign bus.update_seq_counter_o = update_r;
    assign bus.seq_counter_loc_o    = loc_r;
    assign bus.new_seq_num_o        = new_seq_r;
endmodule

// File: tb/tb_seq_num_parser.sv
// Scoreboard bench for seq_num_parser: directed fields push expected verdicts,
// a negedge monitor pops and compares whenever seq_valid_o is seen.
module tb_seq_num_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_num_parser_if #(.BIN_WIDTH(32), .HOST_ADDR(8)) bus ();

    seq_num_parser #(.BIN_WIDTH(32), .MAX_DIGITS(10), .HOST_ADDR(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] seqNum;
        logic [3:0]  width;
        logic        chkNum;
        logic        inSeq;
        logic        gap;
        logic        tooLow;
        logic        fmt;
        logic        upd;
        logic [7:0]  loc;
        logic [31:0] newSeq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   watchBusy = 1'b0;

    function automatic exp_t mk(input logic [31:0] seqNum, input logic [3:0] width,
                                input bit chkNum, input bit inSeq, input bit gap,
                                input bit tooLow, input bit fmt, input logic [7:0] loc);
        exp_t e;
        e.seqNum = seqNum;
        e.width  = width;
        e.chkNum = chkNum;
        e.inSeq  = inSeq;
        e.gap    = gap;
        e.tooLow = tooLow;
        e.fmt    = fmt;
        e.upd    = inSeq;
        e.loc    = loc;
        e.newSeq = seqNum + 32'd1;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("in_seq", 32'(bus.in_seq_o), 32'(e.inSeq));
        cmp("gap", 32'(bus.gap_o), 32'(e.gap));
        cmp("too_low", 32'(bus.too_low_o), 32'(e.tooLow));
        cmp("format_err", 32'(bus.format_err_o), 32'(e.fmt));
        cmp("update", 32'(bus.update_seq_counter_o), 32'(e.upd));
        cmp("busy_at_verdict", 32'(bus.busy_o), 32'd1);
        if (e.chkNum) begin
            cmp("seq_num", bus.seq_num_o, e.seqNum);
            cmp("width", 32'(bus.width_o), 32'(e.width));
        end
        if (e.upd) begin
            cmp("counter_loc", 32'(bus.seq_counter_loc_o), 32'(e.loc));
            cmp("new_seq_num", bus.new_seq_num_o, e.newSeq);
        end
    endtask

    task automatic checkZeros(input string tag);
        $display("[TB] checking cleared outputs: %s", tag);
        cmp("rst_seq_num", bus.seq_num_o, 32'd0);
        cmp("rst_width", 32'(bus.width_o), 32'd0);
        cmp("rst_busy", 32'(bus.busy_o), 32'd0);
        cmp("rst_valid", 32'(bus.seq_valid_o), 32'd0);
        cmp("rst_flags", 32'({bus.in_seq_o, bus.gap_o, bus.too_low_o, bus.format_err_o}), 32'd0);
        cmp("rst_update", 32'(bus.update_seq_counter_o), 32'd0);
        cmp("rst_loc", 32'(bus.seq_counter_loc_o), 32'd0);
        cmp("rst_new_seq", bus.new_seq_num_o, 32'd0);
    endtask

    // Monitor: every verdict must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.seq_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_verdict actual=1 required=0 seq_num=%0d", bus.seq_num_o);
                end else begin
                    checkOutput(sb.pop_front());
                end
            end
            if (watchBusy) cmp("busy_back_to_back", 32'(bus.busy_o), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete field; returns in the cycle where the verdict is due.
    task automatic applyStimulus(input logic [7:0] host, input string digits,
                                 input logic [31:0] expected, input bit endWithLast,
                                 input bit armBusy, input exp_t e);
        bus.field_start_i = 1'b1;
        bus.host_addr_i   = host;
        tick();
        bus.field_start_i = 1'b0;
        bus.host_addr_i   = 8'hEE;
        if (armBusy) watchBusy = 1'b1;
        for (int i = 0; i < digits.len(); i++) begin
            bus.digit_valid_i = 1'b1;
            bus.digit_i       = digits[i];
            if (endWithLast && i == digits.len() - 1) begin
                bus.field_end_i        = 1'b1;
                bus.expected_seq_num_i = expected;
                sb.push_back(e);
            end
            tick();
        end
        bus.digit_valid_i = 1'b0;
        bus.digit_i       = 8'h00;
        if (!endWithLast || digits.len() == 0) begin
            bus.field_end_i        = 1'b1;
            bus.expected_seq_num_i = expected;
            sb.push_back(e);
            tick();
        end
        bus.field_end_i        = 1'b0;
        bus.expected_seq_num_i = 32'hDEAD_BEEF;
    endtask

    initial begin
        bus.field_start_i      = 1'b0;
        bus.digit_valid_i      = 1'b0;
        bus.digit_i            = 8'h00;
        bus.field_end_i        = 1'b0;
        bus.host_addr_i        = 8'h00;
        bus.expected_seq_num_i = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        checkZeros("after power-on reset");
        rst = 1'b0;
        tick();

        applyStimulus(8'h11, "123", 32'd123, 1'b1, 1'b0,
                      mk(32'd123, 4'd3, 1, 1, 0, 0, 0, 8'h11));
        tick();
        applyStimulus(8'h22, "9", 32'd5, 1'b0, 1'b0,
                      mk(32'd9, 4'd1, 1, 0, 1, 0, 0, 8'h22));
        tick();
        applyStimulus(8'h33, "7", 32'd50, 1'b0, 1'b0,
                      mk(32'd7, 4'd1, 1, 0, 0, 1, 0, 8'h33));
        tick();
        applyStimulus(8'h44, "4294967295", 32'hFFFF_FFFF, 1'b1, 1'b0,
                      mk(32'hFFFF_FFFF, 4'd10, 1, 1, 0, 0, 0, 8'h44));
        tick();
        applyStimulus(8'h45, "4294967296", 32'd0, 1'b1, 1'b0,
                      mk(32'hFFFF_FFFF, 4'd10, 1, 0, 0, 0, 1, 8'h45));
        tick();
        applyStimulus(8'h46, "12345678901", 32'd0, 1'b1, 1'b0,
                      mk(32'hFFFF_FFFF, 4'd11, 1, 0, 0, 0, 1, 8'h46));
        tick();
        applyStimulus(8'h47, "1A", 32'd1, 1'b1, 1'b0,
                      mk(32'd0, 4'd0, 0, 0, 0, 0, 1, 8'h47));
        tick();
        applyStimulus(8'h48, "007", 32'd7, 1'b0, 1'b0,
                      mk(32'd0, 4'd0, 0, 0, 0, 0, 1, 8'h48));
        tick();
        applyStimulus(8'h49, "0", 32'd0, 1'b1, 1'b0,
                      mk(32'd0, 4'd1, 1, 1, 0, 0, 0, 8'h49));
        tick();
        applyStimulus(8'h4A, "", 32'd0, 1'b0, 1'b0,
                      mk(32'd0, 4'd0, 1, 0, 0, 0, 1, 8'h4A));
        tick();

        // Digits and field_end_i while idle must not produce anything.
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = "5";
        bus.field_end_i   = 1'b1;
        tick();
        bus.digit_valid_i = 1'b0;
        bus.field_end_i   = 1'b0;
        tick();

        // Abandoned field: "12" under host 0x55, restart under host 0x66.
        bus.field_start_i = 1'b1;
        bus.host_addr_i   = 8'h55;
        tick();
        bus.field_start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.digit_valid_i = 1'b1;
            bus.digit_i       = (i == 0) ? 8'h31 : 8'h32;
            tick();
        end
        bus.digit_valid_i = 1'b0;
        applyStimulus(8'h66, "3", 32'd3, 1'b1, 1'b0,
                      mk(32'd3, 4'd1, 1, 1, 0, 0, 0, 8'h66));
        tick();

        // Back-to-back: second field_start_i lands in the first CHECK cycle.
        applyStimulus(8'h77, "8", 32'd8, 1'b1, 1'b1,
                      mk(32'd8, 4'd1, 1, 1, 0, 0, 0, 8'h77));
        applyStimulus(8'h88, "100", 32'd99, 1'b0, 1'b0,
                      mk(32'd100, 4'd3, 1, 0, 1, 0, 0, 8'h88));
        tick();
        watchBusy = 1'b0;
        tick();

        // Reset in the middle of "45": no verdict, everything cleared.
        bus.field_start_i = 1'b1;
        bus.host_addr_i   = 8'h99;
        tick();
        bus.field_start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.digit_valid_i = 1'b1;
            bus.digit_i       = (i == 0) ? 8'h34 : 8'h35;
            tick();
        end
        bus.digit_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkZeros("after mid-field reset");
        bus.field_end_i        = 1'b1;
        bus.expected_seq_num_i = 32'd45;
        tick();
        bus.field_end_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        cmp("pending_verdicts", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
